fsm_table_ctrl: RTL

//  Programmable controller for the table-driven state machine: replaces the fixed

---
 rtl/fsm_table_pkg.sv | 29 ++
 rtl/fsm_table_mem.sv | 46 ++++
 rtl/fsm_table_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/fsm_table_pkg.sv
// Shared types and constants for the programmable table-driven state machine.
// Entry layout is {next_state, c}; table address is {A, state}.
package fsm_table_pkg;

  localparam int ST_W    = 3;
  localparam int IN_W    = 2;
  localparam int OUT_W   = 3;
  localparam int ADDR_W  = IN_W + ST_W;
  localparam int ENTRY_W = ST_W + OUT_W;
  localparam int NS_LSB  = 3;
  localparam int C_LSB   = 0;

  typedef enum logic [1:0] {
    CFG = 2'd0,
    RUN = 2'd1,
    ERR = 2'd2
  } mode_e;

  typedef struct packed {
    logic [ST_W-1:0]  ns;
    logic [OUT_W-1:0] c;
  } entry_t;

  function automatic logic [ADDR_W-1:0] table_addr(input logic [IN_W-1:0] a,
                                                   input logic [ST_W-1:0] s);
    return {a, s};
  endfunction

endpackage

// File: rtl/fsm_table_mem.sv
// Transition table storage: 2^ADDR_W entries with a per-entry written flag.
// Synchronous write, asynchronous read; res clears only the flags, never the contents.
module fsm_table_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 6,
  localparam int DEPTH = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  vld_reg;
  logic [DEPTH-1:0]  hit;

  // A write coinciding with reset is dropped, so contents and flags stay consistent.
  always_ff @(posedge clk) begin
    if (we && !res) begin
      mem_reg[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = we && (waddr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= vld_reg | hit;
    end
  end

  assign rdata  = mem_reg[raddr];
  assign rvalid = vld_reg[raddr];

endmodule

// File: rtl/fsm_table_ctrl.sv
// Programmable table-driven controller: CFG loads the table, RUN walks it, ERR traps on
// an unwritten entry. Optional `STEP_MODE_EN adds a step input gating each RUN advance.
module fsm_table_ctrl
  import fsm_table_pkg::*;
#(
  parameter int  ST_W   = fsm_table_pkg::ST_W,
  parameter int  IN_W   = fsm_table_pkg::IN_W,
  parameter int  OUT_W  = fsm_table_pkg::OUT_W,
  localparam int ADDR_W = IN_W + ST_W
) (
  input  logic                  clk,
  input  logic                  res,
`ifdef STEP_MODE_EN
  input  logic                  step,
`endif
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [ST_W+OUT_W-1:0] cfg_data,
  input  logic                  run_req,
  input  logic [IN_W-1:0]       A,
  output logic [OUT_W-1:0]      c,
  output logic [ST_W-1:0]       state,
  output logic                  busy,
  output logic                  err
);

  mode_e                  mode_reg, mode_next;
  logic [ST_W-1:0]        state_reg, state_next;
  logic [OUT_W-1:0]       c_reg, c_next;
  logic [ADDR_W-1:0]      lookup_addr;
  logic [ST_W+OUT_W-1:0]  entry;
  logic                   entry_vld;
  logic                   cfg_we;
  logic                   advance;

`ifdef STEP_MODE_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign cfg_ready   = (mode_reg == CFG);
  assign cfg_we      = cfg_valid && cfg_ready;
  assign lookup_addr = {A, state_reg};

  fsm_table_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (ST_W + OUT_W)
  ) u_mem (
    .clk    (clk),
    .res    (res),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr  (lookup_addr),
    .rdata  (entry),
    .rvalid (entry_vld)
  );

  always_comb begin
    mode_next  = mode_reg;
    state_next = state_reg;
    c_next     = c_reg;
    case (mode_reg)
      CFG: begin
        if (run_req) begin
          mode_next = RUN;
        end
      end
      RUN: begin
        // Leaving RUN wins over the lookup, and ignores step.
        if (!run_req) begin
          mode_next  = CFG;
          state_next = '0;
          c_next     = '0;
        end else if (advance) begin
          if (entry_vld) begin
            state_next = entry[NS_LSB +: ST_W];
            c_next     = entry[C_LSB +: OUT_W];
          end else begin
            mode_next = ERR;
            c_next    = '0;
          end
        end
      end
      ERR: begin
        c_next = '0;
      end
      default: begin
        mode_next  = CFG;
        state_next = '0;
        c_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mode_reg  <= CFG;
      state_reg <= '0;
      c_reg     <= '0;
    end else begin
      mode_reg  <= mode_next;
      state_reg <= state_next;
      c_reg     <= c_next;
    end
  end

  assign c     = c_reg;
  assign state = state_reg;
  assign busy  = (mode_reg == RUN);
  assign err   = (mode_reg == ERR);

endmodule
